mux_rr_reg: RTL and testbench
=============================

MUX_RR_REG -- requirements
Module: mux_rr_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 53, data width per channel (legal range 1..64).
REQ-002 The block SHALL have parameter CHANNELS, default 4, number of input channels (legal range 2..16); SELW = clog2(CHANNELS).
REQ-003 clk  input  1  the only clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-005 in_data  input  CHANNELS*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-006 in_valid  input  CHANNELS  per-channel request; bit i qualifies channel i data.
REQ-007 in_ready  output  CHANNELS  per-channel accept; at most one bit high in any cycle.
REQ-008 out_data  output  WIDTH  registered data of the accepted channel.
REQ-009 out_sel  output  SELW  registered index of the channel that supplied out_data.
REQ-010 out_valid  output  1  out_data/out_sel hold a beat not yet consumed.
REQ-011 out_ready  input  1  downstream accepts the beat when high with out_valid.

Function
REQ-012 load = (!out_valid || out_ready) && (in_valid != 0); load SHALL be computed combinationally each cycle.
REQ-013 The arbiter SHALL grant exactly one valid channel when load is 1, and none otherwise.
REQ-014 in_ready[g] SHALL be 1 only for granted channel g, only when load is 1; in_ready SHALL depend on in_valid and out_ready, not on in_data.
REQ-015 On a rising edge with load, out_data <= channel g data, out_sel <= g, out_valid <= 1; latency from acceptance to out_valid is exactly 1 cycle.
REQ-016 On a rising edge with out_valid && out_ready and no load, out_valid <= 0; out_data and out_sel SHALL hold their last values.
REQ-017 A simultaneous consume (out_ready) and load SHALL pass a new beat every cycle with no bubble; full throughput is 1 beat/cycle.
REQ-018 While out_valid && !out_ready, out_data, out_sel and out_valid SHALL stay stable, and all in_ready bits SHALL be 0.
REQ-019 The arbiter SHALL keep a SELW-bit pointer ptr; the search starts at ptr and proceeds ptr, ptr+1, ..., wrapping from CHANNELS-1 to 0.
REQ-020 After each load with grant g, ptr <= (g == CHANNELS-1) ? 0 : g+1; without a load, ptr SHALL hold.
REQ-021 A channel whose in_valid drops before grant SHALL be skipped with no state change.
REQ-022 No arithmetic overflow: ptr wraparound SHALL be explicit for non-power-of-two CHANNELS (e.g. 3, 5).

Reset
REQ-023 While reset_n is 0 at a rising edge: out_valid <= 0, out_data <= 0, out_sel <= 0, ptr <= 0.
REQ-024 While reset_n is 0, in_ready SHALL be all 0 combinationally; no beat SHALL be accepted.
REQ-025 Reset asserted mid-stall SHALL discard the held beat; the first post-reset grant SHALL start search at channel 0.

Configuration
REQ-026 With macro MUX_RR_ROUND_ROBIN_EN defined, arbitration SHALL be round-robin per REQ-019..REQ-020.
REQ-027 Without MUX_RR_ROUND_ROBIN_EN, arbitration SHALL be fixed priority, lowest valid index wins; ptr SHALL not exist; all other behaviour SHALL be identical.

Verification
REQ-028 Reset: reset_n=0 for 2 cycles with all in_valid=1 -> out_valid=0, out_data=0, out_sel=0, in_ready=0000.
REQ-029 Single channel: WIDTH=53, in_valid=0100, ch2 data=53'd321, out_ready=1 -> in_ready=0100 same cycle; next cycle out_valid=1, out_data=321, out_sel=2.
REQ-030 Round-robin (macro defined): in_valid=1111 held, ch i data=i+10, out_ready=1 -> out_sel sequence 0,1,2,3,0 on 5 consecutive cycles, out_data 10,11,12,13,10, no bubbles.
REQ-031 Fixed priority (macro undefined): same stimulus as REQ-030 -> out_sel=0 and out_data=10 on every cycle; in_ready=0001 throughout.
REQ-032 Backpressure: beat loaded with out_data=12, then out_ready=0 for 3 cycles with in_valid=0011 -> out_data=12, out_valid=1 stable, in_ready=0000; out_ready=1 -> next grant per arbitration mode, loaded next cycle.
REQ-033 Narrow/odd config: WIDTH=11, CHANNELS=3, macro defined, in_valid=111, ch data 11'd321/11'd12/11'd7 -> out_sel 0,1,2,0, confirming wrap from 2 to 0.

Source files
------------

// File: rtl/mux_rr_if.sv
// mux_rr_if: channel-packed request side and registered output beat for mux_rr_reg.
interface mux_rr_if #(
    parameter int WIDTH    = 53,
    parameter int CHANNELS = 4
);
    localparam int SELW = $clog2(CHANNELS);
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_ready;
    logic [WIDTH-1:0]          out_data;
    logic [SELW-1:0]           out_sel;
    logic                      out_valid;
    logic                      out_ready;
    modport master (output in_data, in_valid, out_ready, input in_ready, out_data, out_sel, out_valid);
    modport slave  (input in_data, in_valid, out_ready, output in_ready, out_data, out_sel, out_valid);
endinterface

// File: rtl/mux_rr_reg.sv
// mux_rr_reg: N-channel arbitrating mux with one registered output beat.
// Round-robin with MUX_RR_ROUND_ROBIN_EN defined, otherwise fixed priority (lowest index wins).
module mux_rr_reg #(
    parameter int WIDTH    = 53,
    parameter int CHANNELS = 4
) (
    input  logic     clk,
    input  logic     reset_n,
    mux_rr_if.slave  bus
);
    localparam int SELW = $clog2(CHANNELS);
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SELW-1:0]  out_sel_q, out_sel_d;
    logic             out_valid_q, out_valid_d;
    logic [SELW-1:0]  gnt, idx;
    logic             found, load;
`ifdef MUX_RR_ROUND_ROBIN_EN
    logic [SELW-1:0]  ptr_q, ptr_d;
`endif
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
`ifdef MUX_RR_ROUND_ROBIN_EN
            // explicit wrap keeps non-power-of-two channel counts in range
            idx = (k != 0 && ptr_q >= SELW'(CHANNELS - k)) ? ptr_q - SELW'(CHANNELS - k) : ptr_q + SELW'(k);
`else
            idx = SELW'(k);
`endif
            if (!found && bus.in_valid[idx]) begin
                gnt   = idx;
                found = 1'b1;
            end
        end
        load         = reset_n && (!out_valid_q || bus.out_ready) && found;
        bus.in_ready = load ? (CHANNELS'(1) << gnt) : '0;
        out_data_d   = load ? bus.in_data[int'(gnt) * WIDTH +: WIDTH] : out_data_q;
        out_sel_d    = load ? gnt : out_sel_q;
        out_valid_d  = load ? 1'b1 : (bus.out_ready ? 1'b0 : out_valid_q);
`ifdef MUX_RR_ROUND_ROBIN_EN
        ptr_d        = load ? ((gnt == SELW'(CHANNELS - 1)) ? '0 : gnt + 1'b1) : ptr_q;
`endif
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_data_q  <= '0;
            out_sel_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            out_valid_q <= out_valid_d;
        end
    end
`ifdef MUX_RR_ROUND_ROBIN_EN
    always_ff @(posedge clk) begin
        if (!reset_n) ptr_q <= '0;
        else ptr_q <= ptr_d;
    end
`endif
    assign bus.out_data  = out_data_q;
    assign bus.out_sel   = out_sel_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_mux_rr_reg.sv
// tb_mux_rr_reg: directed vector table on a 4x53 instance plus a 3x11 wrap sequence.
module tb_mux_rr_reg;
`ifdef MUX_RR_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    logic clk = 1'b0;
    logic reset_n;
    int tests = 0;
    int fails = 0;
    always #5 clk = ~clk;
    mux_rr_if #(.WIDTH(53), .CHANNELS(4)) b0 ();
    mux_rr_if #(.WIDTH(11), .CHANNELS(3)) b1 ();
    mux_rr_reg #(.WIDTH(53), .CHANNELS(4)) u0 (.clk(clk), .reset_n(reset_n), .bus(b0.slave));
    mux_rr_reg #(.WIDTH(11), .CHANNELS(3)) u1 (.clk(clk), .reset_n(reset_n), .bus(b1.slave));
    typedef struct {
        logic        rn;
        logic [3:0]  v;
        logic        r;
        logic [52:0] d2;
        logic [3:0]  rdy;
        logic        ov;
        logic [52:0] od;
        logic [1:0]  os;
    } vec_t;
    vec_t tv[20];
    function automatic vec_t mk(logic rn, logic [3:0] v, logic r, logic [52:0] d2,
                                logic [3:0] rdy, logic ov, logic [52:0] od, logic [1:0] os);
        mk = '{rn, v, r, d2, rdy, ov, od, os};
    endfunction
    task automatic chk(string name, int n, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s[%0d]: got %0d expected %0d", name, n, act, exp);
        end
    endtask
    initial begin
        tv[0]  = mk(0, 4'b1111, 1, 53'd12,  4'b0000, 0, 53'd0,   2'd0);
        tv[1]  = mk(0, 4'b1111, 1, 53'd12,  4'b0000, 0, 53'd0,   2'd0);
        tv[2]  = mk(1, 4'b0100, 1, 53'd321, 4'b0100, 1, 53'd321, 2'd2);
        tv[3]  = mk(1, 4'b0000, 1, 53'd321, 4'b0000, 0, 53'd321, 2'd2);
        tv[4]  = mk(0, 4'b1111, 1, 53'd12,  4'b0000, 0, 53'd0,   2'd0);
        tv[5]  = mk(1, 4'b1111, 1, 53'd12,  4'b0001, 1, 53'd10,  2'd0);
        tv[6]  = mk(1, 4'b1111, 1, 53'd12,  RR ? 4'b0010 : 4'b0001, 1, RR ? 53'd11 : 53'd10, RR ? 2'd1 : 2'd0);
        tv[7]  = mk(1, 4'b1111, 1, 53'd12,  RR ? 4'b0100 : 4'b0001, 1, RR ? 53'd12 : 53'd10, RR ? 2'd2 : 2'd0);
        tv[8]  = mk(1, 4'b1111, 1, 53'd12,  RR ? 4'b1000 : 4'b0001, 1, RR ? 53'd13 : 53'd10, RR ? 2'd3 : 2'd0);
        tv[9]  = mk(1, 4'b1111, 1, 53'd12,  4'b0001, 1, 53'd10,  2'd0);
        tv[10] = mk(1, 4'b0100, 1, 53'd12,  4'b0100, 1, 53'd12,  2'd2);
        tv[11] = mk(1, 4'b0011, 0, 53'd12,  4'b0000, 1, 53'd12,  2'd2);
        tv[12] = mk(1, 4'b0011, 0, 53'd12,  4'b0000, 1, 53'd12,  2'd2);
        tv[13] = mk(1, 4'b0011, 0, 53'd12,  4'b0000, 1, 53'd12,  2'd2);
        tv[14] = mk(1, 4'b0011, 1, 53'd12,  4'b0001, 1, 53'd10,  2'd0);
        tv[15] = mk(1, 4'b0011, 1, 53'd12,  RR ? 4'b0010 : 4'b0001, 1, RR ? 53'd11 : 53'd10, RR ? 2'd1 : 2'd0);
        tv[16] = mk(1, 4'b0000, 0, 53'd12,  4'b0000, 1, RR ? 53'd11 : 53'd10, RR ? 2'd1 : 2'd0);
        tv[17] = mk(0, 4'b1111, 0, 53'd12,  4'b0000, 0, 53'd0,   2'd0);
        tv[18] = mk(1, 4'b1010, 1, 53'd12,  4'b0010, 1, 53'd11,  2'd1);
        tv[19] = mk(1, 4'b0000, 1, 53'd12,  4'b0000, 0, 53'd11,  2'd1);
        b1.in_data   = {11'd7, 11'd12, 11'd321};
        b1.in_valid  = 3'b000;
        b1.out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            reset_n      = tv[i].rn;
            b0.in_valid  = tv[i].v;
            b0.out_ready = tv[i].r;
            b0.in_data   = {53'd13, tv[i].d2, 53'd11, 53'd10};
            #1;
            chk("in_ready", i, 64'(b0.in_ready), 64'(tv[i].rdy));
            @(posedge clk);
            #1;
            chk("out_valid", i, 64'(b0.out_valid), 64'(tv[i].ov));
            chk("out_data", i, 64'(b0.out_data), 64'(tv[i].od));
            chk("out_sel", i, 64'(b0.out_sel), 64'(tv[i].os));
        end
        reset_n     = 1'b0;
        b1.in_valid = 3'b111;
        repeat (2) @(posedge clk);
        #1;
        chk("n3_reset_valid", 0, 64'(b1.out_valid), 64'd0);
        chk("n3_reset_ready", 0, 64'(b1.in_ready), 64'd0);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            logic [1:0]  es;
            logic [10:0] ed;
            es = RR ? 2'(i % 3) : 2'd0;
            ed = (es == 2'd0) ? 11'd321 : (es == 2'd1) ? 11'd12 : 11'd7;
            #1;
            chk("n3_in_ready", i, 64'(b1.in_ready), 64'(3'b001 << es));
            @(posedge clk);
            #1;
            chk("n3_out_valid", i, 64'(b1.out_valid), 64'd1);
            chk("n3_out_sel", i, 64'(b1.out_sel), 64'(es));
            chk("n3_out_data", i, 64'(b1.out_data), 64'(ed));
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
